// File: rtl/parallel_serializer.sv
// parallel_serializer: loads a W-bit word and sends it LSB first, one bit per shift_en.
// Optional even-parity bit after the data when SERIALIZER_PARITY_EN is defined.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   load_valid - request to load D
//   D          - parallel word, sampled only when a load is accepted
//   load_ready - high in IDLE when abort is low (combinational)
//   shift_en   - consumer strobe; advances to the next bit
//   abort      - synchronous cancel of the word in flight; highest priority
//   out_bit    - current serial bit (0 in IDLE)
//   out_valid  - high while a bit is presented
//   done       - one-cycle pulse in the first IDLE cycle after a completed word
//
// Configuration macro: SERIALIZER_PARITY_EN

module parallel_serializer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    input  logic [W-1:0] D,
    output logic         load_ready,
    input  logic         shift_en,
    input  logic         abort,
    output logic         out_bit,
    output logic         out_valid,
    output logic         done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [W-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
`ifdef SERIALIZER_PARITY_EN
    logic          par_q, par_d;
`endif

    assign load_ready = (state_q == IDLE) && !abort;
    assign out_valid  = (state_q != IDLE);
    assign done       = done_q;

    always_comb begin
        out_bit = 1'b0;
        unique case (state_q)
            SHIFT:   out_bit = sreg_q[0];
`ifdef SERIALIZER_PARITY_EN
            PARITY:  out_bit = par_q;
`endif
            default: out_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        if (abort) begin
            // Cancel wins over load and shift; no done for a cancelled word.
            state_d = IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
            par_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        sreg_d  = D;
                        cnt_d   = '0;
                        state_d = SHIFT;
`ifdef SERIALIZER_PARITY_EN
                        par_d   = ^D;
`endif
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        sreg_d = {1'b0, sreg_q[W-1:1]};
                        if (cnt_q == LAST) begin
                            // Counter is cleared on exit so it never wraps.
                            cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = IDLE;
                            done_d  = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                PARITY: begin
                    if (shift_en) begin
                        state_d = IDLE;
                        par_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_parallel_serializer.sv
// tb_parallel_serializer: directed scoreboard bench for parallel_serializer.
// Uses a W=8 instance for most cases and a W=16 instance for abort.

module tb_parallel_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk;
    logic        rst;
    logic        shift_en;
    logic        abort;
    logic        lv8, lv16;
    logic [7:0]  D8;
    logic [15:0] D16;
    logic        lr8, ob8, ov8, dn8;
    logic        lr16, ob16, ov16, dn16;

    int n_assert;
    int n_fail;
    logic exp_q[$];

    parallel_serializer #(.W(8)) u8 (
        .clk(clk), .rst(rst), .load_valid(lv8), .D(D8),
        .load_ready(lr8), .shift_en(shift_en), .abort(abort),
        .out_bit(ob8), .out_valid(ov8), .done(dn8)
    );

    parallel_serializer #(.W(16)) u16 (
        .clk(clk), .rst(rst), .load_valid(lv16), .D(D16),
        .load_ready(lr16), .shift_en(shift_en), .abort(abort),
        .out_bit(ob16), .out_valid(ov16), .done(dn16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a word on the W=8 instance and queue its expected bit stream.
    task automatic load8(input logic [7:0] d);
        chk("load_ready_before_load", lr8, 1);
        lv8 = 1'b1;
        D8  = d;
        tick();
        lv8 = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (PAR == 1) exp_q.push_back(^d);
    endtask

    // Consume the queued bits; shift_en stays low for the first 'stall' cycles.
    // With poke set, a load of a different word is attempted mid-word.
    task automatic drain(input string tag, input int stall, input bit poke);
        int c;
        c = 1;
        while (exp_q.size() > 0) begin
            if (c > 60) begin
                chk({tag, "_timeout"}, c, 0);
                exp_q.delete();
                break;
            end
            chk({tag, "_out_valid"}, ov8, 1);
            chk({tag, "_out_bit"}, ob8, exp_q[0]);
            chk({tag, "_done_early"}, dn8, 0);
            chk({tag, "_load_ready_busy"}, lr8, 0);
            if (poke) begin
                lv8 = (c >= 2 && c <= 4);
                D8  = 8'hFF;
            end
            shift_en = (c > stall);
            if (shift_en) void'(exp_q.pop_front());
            tick();
            c++;
        end
        lv8 = 1'b0;
        shift_en = 1'b0;
        chk({tag, "_done"}, dn8, 1);
        chk({tag, "_done_cycle"}, c, 8 + 1 + stall + PAR);
        chk({tag, "_idle_valid"}, ov8, 0);
        chk({tag, "_idle_bit"}, ob8, 0);
        tick();
        chk({tag, "_done_pulse_end"}, dn8, 0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        shift_en = 1'b0;
        abort    = 1'b0;
        lv8      = 1'b0;
        lv16     = 1'b0;
        D8       = '0;
        D16      = '0;

        #2;
        chk("rst_out_valid", ov8, 0);
        chk("rst_out_bit", ob8, 0);
        chk("rst_done", dn8, 0);
        chk("rst16_out_valid", ov16, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_load_ready", lr8, 1);
        chk("rst16_load_ready", lr16, 1);

        // Basic word, first load right after reset release.
        load8(8'hA5);
        drain("basic", 0, 1'b0);

        // Stall after bit 0.
        load8(8'h01);
        drain("stall", 3, 1'b0);

        // Abort on the W=16 instance at bit 5.
        chk("ab_ready", lr16, 1);
        lv16 = 1'b1;
        D16  = 16'hFFFF;
        tick();
        lv16 = 1'b0;
        shift_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("ab_bit", ob16, 1);
            chk("ab_valid", ov16, 1);
            tick();
        end
        chk("ab_bit5", ob16, 1);
        abort = 1'b1;
        #1;
        chk("ab_ready_during_abort", lr16, 0);
        tick();
        abort = 1'b0;
        shift_en = 1'b0;
        #1;
        chk("ab_idle_valid", ov16, 0);
        chk("ab_idle_bit", ob16, 0);
        chk("ab_no_done", dn16, 0);
        chk("ab_load_ready", lr16, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ab_no_done_later", dn16, 0);
        end

        // Abort and load together in IDLE: no load.
        abort = 1'b1;
        lv8   = 1'b1;
        D8    = 8'hFF;
        #1;
        chk("sim_ready_low", lr8, 0);
        tick();
        abort = 1'b0;
        lv8   = 1'b0;
        #1;
        chk("sim_no_load", ov8, 0);
        tick();
        chk("sim_still_idle", ov8, 0);
        chk("sim_no_done", dn8, 0);

        // Load attempt mid-word with different D is ignored.
        load8(8'h5A);
        drain("midload", 0, 1'b1);

        // Reset mid-word at bit 3 of 8'h3C.
        load8(8'h3C);
        shift_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rw_bit", ob8, exp_q[0]);
            void'(exp_q.pop_front());
            tick();
        end
        chk("rw_bit3", ob8, 1);
        chk("rw_valid3", ov8, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rw_async_valid", ov8, 0);
        chk("rw_async_bit", ob8, 0);
        chk("rw_async_done", dn8, 0);
        exp_q.delete();
        shift_en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rw_ready_after", lr8, 1);
        chk("rw_no_done", dn8, 0);
        chk("rw_idle_valid", ov8, 0);
        load8(8'hC3);
        drain("after_rst", 0, 1'b0);

`ifdef SERIALIZER_PARITY_EN
        load8(8'h07);
        chk("par07_bit", exp_q[8], 1);
        drain("par07", 0, 1'b0);
        load8(8'hA5);
        chk("parA5_bit", exp_q[8], 0);
        drain("parA5", 0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/parallel_serializer.md
PARALLEL_SERIALIZER -- requirements
Module: parallel_serializer

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the parallel data width in bits (W >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the system reset, asynchronous and active-low.
REQ-004 The block SHALL have port load_valid, input, 1 bit, which requests a load of D.
REQ-005 The block SHALL have port D, input, W bits, the parallel word to transmit.
REQ-006 The block SHALL have port load_ready, output, 1 bit, which is high when a load can be accepted.
REQ-007 The block SHALL have port shift_en, input, 1 bit, the consumer advance strobe for the current bit.
REQ-008 The block SHALL have port abort, input, 1 bit, a synchronous cancel of the word in flight.
REQ-009 The block SHALL have port out_bit, output, 1 bit, the current serial bit.
REQ-010 The block SHALL have port out_valid, output, 1 bit, which is high when out_bit is meaningful.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse after the last bit is consumed.

Function
REQ-012 The block SHALL implement an FSM with states IDLE and SHIFT, plus PARITY when SERIALIZER_PARITY_EN is defined.
REQ-013 The block SHALL drive load_ready high exactly when the state is IDLE and abort is low; this is combinational.
REQ-014 On a clock edge with load_valid && load_ready, the block SHALL capture D into an internal W-bit register, clear the bit counter to 0, and enter SHIFT.
REQ-015 In SHIFT and PARITY, out_valid SHALL be 1; in IDLE, out_valid SHALL be 0 and out_bit SHALL be 0.
REQ-016 Bits SHALL be sent LSB first, so that a serial-in shift register filling from its MSB holds D unchanged after W shifts.
REQ-017 In SHIFT, out_bit SHALL equal register bit 0.
REQ-018 On each edge with shift_en=1 in SHIFT, the register SHALL shift right by one with 0 filled at the MSB, and the counter SHALL increment.
REQ-019 When shift_en=0, all state SHALL hold, allowing an unlimited stall.
REQ-020 The first bit SHALL be presented in the cycle after load acceptance, giving 1-cycle latency.
REQ-021 Counter width SHALL be $clog2(W) bits, and the counter SHALL never wrap within a word.
REQ-022 When the counter equals W-1 and shift_en=1, the FSM SHALL go to IDLE, or to PARITY if that feature is enabled.
REQ-023 In PARITY, the FSM SHALL go to IDLE on shift_en=1.
REQ-024 done SHALL be registered and SHALL go high for exactly the first cycle in IDLE after a completed word; it SHALL not assert after an abort.
REQ-025 abort=1 on any edge SHALL force IDLE, clear the register and counter, and suppress done.
REQ-026 abort SHALL take priority over load_valid and shift_en when they occur in the same cycle.
REQ-027 load_valid SHALL be ignored outside IDLE; D is sampled only at acceptance, so D changes mid-word SHALL have no effect.
REQ-028 Back-to-back words SHALL require one IDLE cycle between them, giving minimum period W+1 cycles (W+2 with parity).

Reset
REQ-029 While rst=0, the block SHALL hold state IDLE, register 0, counter 0, out_bit 0, out_valid 0 and done 0; load_ready SHALL be 1 once rst is high.
REQ-030 Reset asserted mid-word SHALL discard the word immediately without waiting for a clock, and no done SHALL follow.
REQ-031 The first load SHALL be accepted on the first clk edge after rst deasserts.

Configuration
REQ-032 When macro SERIALIZER_PARITY_EN is defined, the block SHALL send one even-parity bit, the XOR of all W captured bits, after the W data bits in state PARITY.
REQ-033 Without SERIALIZER_PARITY_EN, the PARITY state and its logic SHALL be absent, and done SHALL follow the W-th data bit.

Verification
REQ-034 The bench SHALL cover a basic word: W=8, load 8'hA5, shift_en=1 continuously -> out_bit 1,0,1,0,0,1,0,1 over cycles 1..8, done high at cycle 9, out_valid low at cycle 9.
REQ-035 The bench SHALL cover a stall: W=8, load 8'h01, shift_en low for 3 cycles after bit 0 -> out_bit held at 1 with out_valid=1 for 4 cycles, then 0s, with done 3 cycles later than in the no-stall case.
REQ-036 The bench SHALL cover abort: W=16, load 16'hFFFF, abort at bit 5 -> IDLE next cycle, out_valid=0, no done, load_ready=1.
REQ-037 The bench SHALL cover simultaneous events: abort and load_valid together in IDLE -> no load, out_valid stays 0; load_valid during SHIFT with D changed -> transmitted bits still from the original word.
REQ-038 The bench SHALL cover reset mid-word: rst low at bit 3 of 8'h3C -> outputs 0 asynchronously, no done after release, and the next load of 8'hC3 sends 1,1,0,0,0,0,1,1.
REQ-039 The bench SHALL cover parity with SERIALIZER_PARITY_EN defined: load 8'h07 -> 8 data bits, then out_bit=1 as the 9th bit, done at cycle 10; load 8'hA5 -> parity bit 0.
